spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// spi_master: command-driven SPI frame engine. A frame starts one cycle after acceptance, and rd_valid pulses one cycle after the last MISO sample.
// Backpressure is through cmd_ready. Define SPI_MASTER_CMD_FIFO_EN for a 4-entry command FIFO; the default is a single command slot.
module spi_master #(
  parameter int TURNAROUND = 1,
  parameter int IDLE_GAP   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {IDLE, OPCODE, PAYLOAD, TURN, CAPTURE, GAP} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] op_q;
  logic [7:0] dat_q;
  logic [7:0] shift_q;
  logic       cap_done;
  logic       run;
  logic       q_vld;
  logic [1:0] q_op;
  logic [7:0] q_dat;
  logic       push, launch, gap_last;
  logic       ss_nxt, mosi_nxt;
  logic [1:0] frm_op;
  logic [7:0] frm_dat;
  logic [2:0] opcode;

  assign push     = cmd_valid && cmd_ready;
  assign gap_last = (state == GAP) && (cnt == 4'd0);
  assign launch   = q_vld && ((state == IDLE) || gap_last);
  assign busy     = (state != IDLE) || q_vld;
  assign frm_op   = launch ? q_op  : op_q;
  assign frm_dat  = launch ? q_dat : dat_q;
  assign opcode   = {frm_op[1], frm_op[1], frm_op[0]};

`ifdef SPI_MASTER_CMD_FIFO_EN
  logic [1:0] f_op  [4];
  logic [7:0] f_dat [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] f_cnt;

  // A pop does not free a slot for the same cycle, so a full FIFO always refuses.
  assign cmd_ready = run && (f_cnt != 3'd4);
  assign q_vld     = (f_cnt != 3'd0);
  assign q_op      = f_op[rd_ptr];
  assign q_dat     = f_dat[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      f_cnt  <= 3'd0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 2'd1;
      if (launch) rd_ptr <= rd_ptr + 2'd1;
      f_cnt <= f_cnt + 3'(push) - 3'(launch);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_op[wr_ptr]  <= cmd_op;
      f_dat[wr_ptr] <= cmd_data;
    end
  end
`else
  logic       pend_vld;
  logic [1:0] pend_op;
  logic [7:0] pend_dat;

  // Accepting during GAP lets the next frame launch exactly as the gap closes.
  assign cmd_ready = run && !pend_vld && ((state == IDLE) || (state == GAP));
  assign q_vld     = pend_vld;
  assign q_op      = pend_op;
  assign q_dat     = pend_dat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_op  <= 2'd0;
      pend_dat <= 8'h00;
    end else if (push) begin
      pend_vld <= 1'b1;
      pend_op  <= cmd_op;
      pend_dat <= cmd_data;
    end else if (launch) begin
      pend_vld <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ss_nxt    = 1'b1;
    mosi_nxt  = 1'b0;
    case (state)
      IDLE: ;
      OPCODE: begin
        if (cnt == 4'd0) begin
          state_nxt = PAYLOAD;
          cnt_nxt   = 4'd7;
        end else cnt_nxt = cnt - 4'd1;
      end
      PAYLOAD: begin
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        else if (op_q != 2'd3) begin
          state_nxt = GAP;
          cnt_nxt   = 4'(IDLE_GAP - 1);
        end else if (TURNAROUND == 0) begin
          state_nxt = CAPTURE;
          cnt_nxt   = 4'd7;
        end else begin
          state_nxt = TURN;
          cnt_nxt   = 4'(TURNAROUND - 1);
        end
      end
      TURN: begin
        if (cnt == 4'd0) begin
          state_nxt = CAPTURE;
          cnt_nxt   = 4'd7;
        end else cnt_nxt = cnt - 4'd1;
      end
      CAPTURE: begin
        if (cnt == 4'd0) begin
          state_nxt = GAP;
          cnt_nxt   = 4'(IDLE_GAP - 1);
        end else cnt_nxt = cnt - 4'd1;
      end
      GAP: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else cnt_nxt = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
    if (launch) begin
      state_nxt = OPCODE;
      cnt_nxt   = 4'd2;
    end
    // Pin values are derived from the next state so they register alongside it.
    case (state_nxt)
      OPCODE: begin
        ss_nxt   = 1'b0;
        mosi_nxt = opcode[cnt_nxt[1:0]];
      end
      PAYLOAD: begin
        ss_nxt   = 1'b0;
        mosi_nxt = frm_dat[cnt_nxt[2:0]];
      end
      TURN, CAPTURE: ss_nxt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_q     <= 2'd0;
      dat_q    <= 8'h00;
      shift_q  <= 8'h00;
      cap_done <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      run      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      SS_n     <= ss_nxt;
      MOSI     <= mosi_nxt;
      run      <= 1'b1;
      if (launch) begin
        op_q  <= q_op;
        dat_q <= q_dat;
      end
      if (state == CAPTURE) shift_q <= {shift_q[6:0], MISO};
      cap_done <= (state == CAPTURE) && (cnt == 4'd0);
      rd_valid <= cap_done;
      if (cap_done) rd_data <= shift_q;
    end
  end

endmodule
